if_prefetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between

---
 rtl/if_pkg.sv | 19 +
 rtl/if_queue.sv | 84 ++++++++
 rtl/if_prefetch_stage.sv | 150 +++++++++++++++
 tb/tb_if_prefetch_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and default sizing for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned IF_XLEN  = 32;
  localparam int unsigned IF_DEPTH = 4;
  localparam int unsigned PTR_W    = $clog2(IF_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIRECT
  } fetch_state_t;

  typedef struct packed {
    logic [IF_XLEN-1:0] instr;
    logic [IF_XLEN-1:0] npc;
  } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// DEPTH-entry circular buffer of fetched {instr, npc} entries with flush.
// When empty the head output holds the most recently popped entry.
module if_queue
  import if_pkg::*;
#(
  parameter int unsigned  DEPTH = IF_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  if_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output if_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  if_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  if_entry_t         last_q, last_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = empty ? last_q : mem_q[rd_ptr_q];

  // A pop in a flush cycle still retires the head into last_q.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_pop) begin
      last_d = mem_q[rd_ptr_q];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential prefetch into a small queue, epoch-tagged
// responses, branch redirect/flush. Optional perf counters under IF_PERF_CNT_EN.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = IF_XLEN,
  parameter int unsigned     DEPTH    = IF_DEPTH,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BRANCH,
  input  logic [XLEN-1:0] EX_MEM_NPC,
  input  logic            PC_WRITE,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IF_ID_VALID,
  input  logic            IF_ID_READY,
  output logic [XLEN-1:0] IF_ID_INSTR,
  output logic [XLEN-1:0] IF_ID_NPC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     FETCH_CNT,
  output logic [31:0]     FLUSH_CNT
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic [XLEN-1:0] inflight_addr_q, inflight_addr_d;

  logic             issue_c;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic [OCC_W-1:0] occupancy;
  if_entry_t        push_entry;
  if_entry_t        head_entry;

  // Counting the in-flight fetch reserves a slot so its response always fits.
  assign occupancy = {1'b0, q_count} + OCC_W'(inflight_q);
  assign issue_c   = (state_q == S_RUN) && PC_WRITE && !BRANCH && !q_full &&
                     (occupancy < OCC_W'(DEPTH));
  assign push_c    = inflight_q && (inflight_epoch_q == epoch_q) && !BRANCH;
  assign pop_c     = !q_empty && IF_ID_READY;

  assign push_entry.instr = IMEM_RDATA;
  assign push_entry.npc   = inflight_addr_q + XLEN'(PC_STEP);

  if_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .flush     (BRANCH),
    .head      (head_entry),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign IMEM_REQ    = issue_c;
  assign IMEM_ADDR   = pc_q;
  assign IF_ID_VALID = !q_empty;
  assign IF_ID_INSTR = head_entry.instr;
  assign IF_ID_NPC   = head_entry.npc;

  // Fetch sequencing: one idle cycle after reset and after every redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:     state_d = S_RUN;
      S_RUN:      state_d = BRANCH ? S_REDIRECT : S_RUN;
      S_REDIRECT: state_d = BRANCH ? S_REDIRECT : S_RUN;
      default:    state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue_c;
    inflight_epoch_d = epoch_q;
    inflight_addr_d  = inflight_addr_q;
    if (BRANCH) begin
      pc_d    = EX_MEM_NPC;
      epoch_d = ~epoch_q;
    end else if (issue_c) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
    if (issue_c) begin
      inflight_addr_d = pc_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q          <= S_BOOT;
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_addr_q  <= inflight_addr_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(pop_c);
    flush_cnt_d = flush_cnt_q + 32'(BRANCH);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: cycle-stepped stimulus, scoreboard of
// expected {instr, npc}, plus a second instance with a wrapping RESET_PC.
module tb_if_prefetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  typedef struct {
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch;
  logic [31:0] ex_mem_npc;
  logic        pc_write;
  logic        if_id_ready;
  logic [31:0] imem_rdata, imem_rdata_w;

  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        if_id_valid, if_id_valid_w;
  logic [31:0] if_id_instr, if_id_instr_w;
  logic [31:0] if_id_npc, if_id_npc_w;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt, fetch_cnt_w, flush_cnt_w;
`endif

  int errors = 0;
  int checks = 0;

  ent_t        expq[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_npc[$];
  logic        resp_v;
  ent_t        resp_e;
  logic [31:0] exp_pc;
  int          pop_cnt;
  logic [31:0] last_npc;
  int          exp_fetch;
  int          exp_flush;

  logic        s_req, s_valid, w_req, w_valid;
  logic [31:0] s_addr, s_instr, s_npc, w_addr, w_npc;

  vec_t boot_tbl[7];
  logic valid_drain[5];
  logic valid_restart[5];

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .XLEN(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK(clk), .RST(rst_n), .BRANCH(branch), .EX_MEM_NPC(ex_mem_npc),
    .PC_WRITE(pc_write), .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr),
    .IMEM_RDATA(imem_rdata), .IF_ID_VALID(if_id_valid), .IF_ID_READY(if_id_ready),
    .IF_ID_INSTR(if_id_instr), .IF_ID_NPC(if_id_npc)
`ifdef IF_PERF_CNT_EN
    , .FETCH_CNT(fetch_cnt), .FLUSH_CNT(flush_cnt)
`endif
  );

  if_prefetch_stage #(
    .XLEN(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .CLK(clk), .RST(rst_n), .BRANCH(branch), .EX_MEM_NPC(ex_mem_npc),
    .PC_WRITE(pc_write), .IMEM_REQ(imem_req_w), .IMEM_ADDR(imem_addr_w),
    .IMEM_RDATA(imem_rdata_w), .IF_ID_VALID(if_id_valid_w), .IF_ID_READY(if_id_ready),
    .IF_ID_INSTR(if_id_instr_w), .IF_ID_NPC(if_id_npc_w)
`ifdef IF_PERF_CNT_EN
    , .FETCH_CNT(fetch_cnt_w), .FLUSH_CNT(flush_cnt_w)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample combinational outputs, update the model, advance.
  task automatic cycle(input logic rdy, input logic pcw, input logic br, input logic [31:0] tgt);
    ent_t e;
    if_id_ready = rdy;
    pc_write    = pcw;
    branch      = br;
    ex_mem_npc  = tgt;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_id_valid;
    s_instr = if_id_instr;
    s_npc   = if_id_npc;
    w_req   = imem_req_w;
    w_addr  = imem_addr_w;
    w_valid = if_id_valid_w;
    w_npc   = if_id_npc_w;

    chk("if_id_valid vs model", 32'(s_valid), 32'(expq.size() != 0));
    if (br) chk("no issue in branch cycle", 32'(s_req), 32'd0);
    if (s_req) begin
      chk("imem_addr", s_addr, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (s_valid && rdy) begin
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("if_id_instr", s_instr, e.instr);
        chk("if_id_npc", s_npc, e.npc);
      end
      last_npc = s_npc;
      pop_cnt++;
      exp_fetch++;
    end
    if (br) begin
      expq.delete();
      exp_pc = tgt;
      exp_flush++;
    end else if (resp_v) begin
      expq.push_back(resp_e);
    end
    resp_v       = s_req;
    resp_e.instr = mem_word(s_addr);
    resp_e.npc   = s_addr + 32'd4;

    if (w_req) wq_addr.push_back(w_addr);
    if (w_valid && rdy) wq_npc.push_back(w_npc);

    @(posedge clk);
    #1;
    imem_rdata   = s_req ? mem_word(s_addr) : 32'd0;
    imem_rdata_w = w_req ? mem_word(w_addr) : 32'd0;
  endtask

  task automatic model_reset();
    expq.delete();
    resp_v    = 1'b0;
    exp_pc    = 32'd0;
    exp_fetch = 0;
    exp_flush = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    logic        found;

    boot_tbl[0] = '{1'b0, 1'b0, 32'h00};
    boot_tbl[1] = '{1'b1, 1'b0, 32'h00};
    boot_tbl[2] = '{1'b1, 1'b0, 32'h04};
    boot_tbl[3] = '{1'b1, 1'b1, 32'h08};
    boot_tbl[4] = '{1'b1, 1'b1, 32'h0C};
    boot_tbl[5] = '{1'b1, 1'b1, 32'h10};
    boot_tbl[6] = '{1'b1, 1'b1, 32'h14};
    valid_drain   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    valid_restart = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n        = 1'b0;
    branch       = 1'b0;
    ex_mem_npc   = 32'd0;
    pc_write     = 1'b0;
    if_id_ready  = 1'b0;
    imem_rdata   = 32'd0;
    imem_rdata_w = 32'd0;
    pop_cnt      = 0;
    last_npc     = 32'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset if_id_valid", 32'(if_id_valid), 32'd0);
    chk("reset if_id_instr", if_id_instr, 32'd0);
    chk("reset if_id_npc", if_id_npc, 32'd0);
    rst_n = 1'b1;

    // Boot and free-running sequential fetch.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      chk($sformatf("boot[%0d] imem_req", i), 32'(s_req), 32'(boot_tbl[i].exp_req));
      chk($sformatf("boot[%0d] if_id_valid", i), 32'(s_valid), 32'(boot_tbl[i].exp_valid));
      if (boot_tbl[i].exp_req) chk($sformatf("boot[%0d] imem_addr", i), s_addr, boot_tbl[i].exp_addr);
    end

    // Wrapping RESET_PC instance.
    chk("wrap addr count", 32'(wq_addr.size() >= 3), 32'd1);
    chk("wrap npc count", 32'(wq_npc.size() >= 2), 32'd1);
    if (wq_addr.size() >= 3) begin
      chk("wrap addr0", wq_addr[0], 32'hFFFF_FFF8);
      chk("wrap addr1", wq_addr[1], 32'hFFFF_FFFC);
      chk("wrap addr2", wq_addr[2], 32'h0000_0000);
    end
    if (wq_npc.size() >= 2) begin
      chk("wrap npc0", wq_npc[0], 32'hFFFF_FFFC);
      chk("wrap npc1", wq_npc[1], 32'h0000_0000);
    end

    // Decode stalled: queue fills to DEPTH and fetching stops.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("full: imem_req low", 32'(s_req), 32'd0);
    chk("full: head valid", 32'(s_valid), 32'd1);

    // Release decode with PC_WRITE low: exactly DEPTH pops, no new fetch.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk($sformatf("drain[%0d] if_id_valid", i), 32'(s_valid), 32'(valid_drain[i]));
      chk($sformatf("drain[%0d] imem_req", i), 32'(s_req), 32'd0);
    end

    // Three queued plus one in flight, then a taken branch to 0x100.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk($sformatf("fill[%0d] imem_req", i), 32'(s_req), 32'd1);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    chk("branch cycle head valid", 32'(s_valid), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("redirect: queue empty", 32'(s_valid), 32'd0);
    chk("redirect: no fetch", 32'(s_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("post-branch imem_req", 32'(s_req), 32'd1);
    chk("post-branch imem_addr", s_addr, 32'h100);
    p0 = 32'(pop_cnt);
    for (int i = 0; i < 6 && 32'(pop_cnt) == p0; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("first npc after branch", last_npc, 32'h104);

    // Back-to-back branches, the last one while PC_WRITE is low.
    cycle(1'b1, 1'b1, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 1'b1, 32'h400);
    cycle(1'b1, 1'b0, 1'b1, 32'h500);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk($sformatf("hazard[%0d] imem_req", i), 32'(s_req), 32'd0);
    end
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      if (s_req) begin
        found = 1'b1;
        chk("resume imem_addr", s_addr, 32'h500);
      end
    end
    chk("resume fetch seen", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Drain, queue two entries, then async reset mid-cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("drained", 32'(s_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    #1;
    chk("two entries before reset", 32'(if_id_valid), 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'(exp_fetch));
    chk("flush_cnt", flush_cnt, 32'(exp_flush));
`endif
    rst_n = 1'b0;
    #1;
    chk("async reset if_id_valid", 32'(if_id_valid), 32'd0);
    chk("async reset imem_req", 32'(imem_req), 32'd0);
    chk("async reset if_id_npc", if_id_npc, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("reset fetch_cnt", fetch_cnt, 32'd0);
    chk("reset flush_cnt", flush_cnt, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    imem_rdata   = 32'd0;
    imem_rdata_w = 32'd0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      chk($sformatf("restart[%0d] if_id_valid", i), 32'(s_valid), 32'(valid_restart[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
